// File: rtl/rob_bank_param.sv
// rob_bank_param: parametrised reorder-buffer bank with compacted multi-lane dispatch,
// multi-port writeback completion, contiguous in-order retire and mispredict flush.
module rob_bank_param #(
  parameter int DEPTH      = 32,
  parameter int TAG_W      = $clog2(DEPTH),
  parameter int DISPATCH_W = 3,
  parameter int WB_PORTS   = 7,
  parameter int RETIRE_W   = 3,
  parameter int PAYLOAD_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DISPATCH_W-1:0]         disp_valid,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
  output logic                          disp_ready,
  output logic [DISPATCH_W*TAG_W-1:0]   disp_tag,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]     wb_tag,
  input  logic [WB_PORTS-1:0]           wb_misp,
  output logic [RETIRE_W-1:0]           ret_valid,
  output logic [RETIRE_W*PAYLOAD_W-1:0] ret_payload,
  output logic [RETIRE_W*TAG_W-1:0]     ret_tag,
  input  logic                          ret_ready,
  output logic                          flush,
  output logic [TAG_W:0]                count,
  output logic                          empty,
  output logic                          full
);
  logic [DEPTH-1:0] valid, complete, misp;
  logic [PAYLOAD_W-1:0] payload [DEPTH];
  logic [TAG_W-1:0] head, tail, idx;
  logic [TAG_W:0] n_disp, n_ret;
  logic disp_fire, chain;
  assign disp_ready = count <= (TAG_W+1)'(DEPTH - DISPATCH_W);
  assign disp_fire  = disp_ready && |disp_valid;
  assign empty      = count == '0;
  assign full       = count == (TAG_W+1)'(DEPTH);
  always_comb begin
    n_disp   = '0;
    disp_tag = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_tag[k*TAG_W +: TAG_W] = tail + n_disp[TAG_W-1:0];
      n_disp = n_disp + (TAG_W+1)'(disp_valid[k]);
    end
  end
  // a misprediction terminates the retire chain after its own lane
  always_comb begin
    chain       = 1'b1;
    idx         = head;
    n_ret       = '0;
    flush       = 1'b0;
    ret_valid   = '0;
    ret_tag     = '0;
    ret_payload = '0;
    for (int j = 0; j < RETIRE_W; j++) begin
      idx = head + TAG_W'(j);
      ret_tag[j*TAG_W +: TAG_W]         = idx;
      ret_payload[j*PAYLOAD_W +: PAYLOAD_W] = payload[idx];
      chain        = chain && valid[idx] && complete[idx];
      ret_valid[j] = chain;
      n_ret        = n_ret + (TAG_W+1)'(chain && ret_ready);
      flush        = flush | (ret_ready && chain && misp[idx]);
      chain        = chain && !misp[idx];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      complete <= '0;
      misp     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (flush) begin
      valid    <= '0;
      complete <= '0;
      misp     <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && valid[wb_tag[p*TAG_W +: TAG_W]]) begin
          complete[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
          if (wb_misp[p]) misp[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
        end
      for (int j = 0; j < RETIRE_W; j++)
        if (ret_ready && ret_valid[j]) begin
          valid[head + TAG_W'(j)]    <= 1'b0;
          complete[head + TAG_W'(j)] <= 1'b0;
          misp[head + TAG_W'(j)]     <= 1'b0;
        end
      for (int k = 0; k < DISPATCH_W; k++)
        if (disp_fire && disp_valid[k]) begin
          valid[disp_tag[k*TAG_W +: TAG_W]]    <= 1'b1;
          complete[disp_tag[k*TAG_W +: TAG_W]] <= 1'b0;
          misp[disp_tag[k*TAG_W +: TAG_W]]     <= 1'b0;
        end
      head  <= head + n_ret[TAG_W-1:0];
      tail  <= tail + (disp_fire ? n_disp[TAG_W-1:0] : '0);
      count <= count + (disp_fire ? n_disp : '0) - n_ret;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < DISPATCH_W; k++)
      if (disp_fire && !flush && disp_valid[k])
        payload[disp_tag[k*TAG_W +: TAG_W]] <= disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
  end
endmodule

// File: tb/tb_rob_bank_param.sv
// tb_rob_bank_param: directed scoreboard bench for rob_bank_param with default parameters.
module tb_rob_bank_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  disp_valid;
  logic [95:0] disp_payload;
  logic        disp_ready;
  logic [14:0] disp_tag;
  logic [6:0]  wb_valid;
  logic [34:0] wb_tag;
  logic [6:0]  wb_misp;
  logic [2:0]  ret_valid;
  logic [95:0] ret_payload;
  logic [14:0] ret_tag;
  logic        ret_ready;
  logic        flush;
  logic [5:0]  count;
  logic        empty;
  logic        full;
  typedef struct {logic [4:0] tag; logic [31:0] pl;} ent_t;
  ent_t sb[$];
  int errs = 0;
  int checks = 0;
  int m_tail = 0;
  rob_bank_param dut (
    .clk(clk), .rst_n(rst_n), .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_ready(disp_ready), .disp_tag(disp_tag), .wb_valid(wb_valid), .wb_tag(wb_tag),
    .wb_misp(wb_misp), .ret_valid(ret_valid), .ret_payload(ret_payload), .ret_tag(ret_tag),
    .ret_ready(ret_ready), .flush(flush), .count(count), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_state(input int c, input bit em, input bit fu, input bit dr);
    chk("count", 64'(count), 64'(c));
    chk("empty", 64'(empty), 64'(em));
    chk("full", 64'(full), 64'(fu));
    chk("disp_ready", 64'(disp_ready), 64'(dr));
  endtask
  task automatic set_wb(input int p, input int t, input bit m);
    wb_valid[p] = 1'b1;
    wb_tag[p*5 +: 5] = 5'(t);
    wb_misp[p] = m;
  endtask
  task automatic clear_wb();
    wb_valid = '0;
    wb_tag   = '0;
    wb_misp  = '0;
  endtask
  task automatic do_disp(input logic [2:0] v, input bit acc);
    int n = 0;
    disp_valid = v;
    for (int k = 0; k < 3; k++) disp_payload[k*32 +: 32] = $urandom;
    #1;
    for (int k = 0; k < 3; k++)
      if (v[k]) begin
        if (acc) begin
          chk("disp_tag", 64'(disp_tag[k*5 +: 5]), 64'((m_tail + n) % 32));
          sb.push_back('{tag: 5'((m_tail + n) % 32), pl: disp_payload[k*32 +: 32]});
        end
        n++;
      end
    if (acc) m_tail = (m_tail + n) % 32;
    cyc();
    disp_valid = '0;
  endtask
  task automatic do_retire(input logic [2:0] rv, input bit fl);
    ent_t e;
    ret_ready = 1'b1;
    #1;
    chk("ret_valid", 64'(ret_valid), 64'(rv));
    chk("flush", 64'(flush), 64'(fl));
    for (int j = 0; j < 3; j++)
      if (rv[j]) begin
        e = sb.pop_front();
        chk("ret_tag", 64'(ret_tag[j*5 +: 5]), 64'(e.tag));
        chk("ret_payload", 64'(ret_payload[j*32 +: 32]), 64'(e.pl));
      end
    cyc();
    ret_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    disp_valid = '0;
    disp_payload = '0;
    ret_ready = 1'b0;
    clear_wb();
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk_state(0, 1, 0, 1);
    chk("reset_ret_valid", 64'(ret_valid), 64'(0));
    chk("reset_flush", 64'(flush), 64'(0));
    // compacted dispatch: 101 at tail=5 lands on tags 5 and 6
    do_disp(3'b111, 1);
    do_disp(3'b011, 1);
    do_disp(3'b101, 1);
    #1;
    chk_state(7, 0, 0, 1);
    // younger completions cannot retire past an incomplete head
    set_wb(0, 1, 0);
    set_wb(6, 2, 0);
    cyc();
    clear_wb();
    #1;
    chk("ret_valid_head_pending", 64'(ret_valid), 64'(0));
    ret_ready = 1'b1;
    cyc();
    ret_ready = 1'b0;
    #1;
    chk("count_idle_retire", 64'(count), 64'(7));
    set_wb(3, 0, 0);
    cyc();
    clear_wb();
    do_retire(3'b111, 0);
    #1;
    chk("count_after_retire", 64'(count), 64'(4));
    // mispredict at tag 4 ends the group and flushes; same-cycle dispatch is dropped
    set_wb(0, 3, 0);
    set_wb(1, 4, 1);
    set_wb(2, 5, 0);
    set_wb(5, 5, 0);
    set_wb(6, 6, 0);
    cyc();
    clear_wb();
    #1;
    chk("ret_valid_misp", 64'(ret_valid), 64'(3'b011));
    chk("no_flush_unready", 64'(flush), 64'(0));
    disp_valid = 3'b111;
    do_retire(3'b011, 1);
    disp_valid = '0;
    sb.delete();
    m_tail = 0;
    #1;
    chk_state(0, 1, 0, 1);
    chk("ret_valid_after_flush", 64'(ret_valid), 64'(0));
    // fill 30, drain through retire so head lands on 30
    for (int i = 0; i < 10; i++) do_disp(3'b111, 1);
    #1;
    chk_state(30, 0, 0, 0);
    for (int b = 0; b < 5; b++) begin
      for (int p = 0; p < 7; p++) if (b*7 + p < 30) set_wb(p, b*7 + p, 0);
      cyc();
      clear_wb();
    end
    for (int i = 0; i < 10; i++) do_retire(3'b111, 0);
    #1;
    chk_state(0, 1, 0, 1);
    for (int i = 0; i < 9; i++) do_disp(3'b111, 1);
    do_disp(3'b011, 1);
    #1;
    chk_state(29, 0, 0, 1);
    do_disp(3'b111, 1);
    #1;
    chk_state(32, 0, 1, 0);
    do_disp(3'b111, 0);
    #1;
    chk("count_blocked", 64'(count), 64'(32));
    set_wb(0, 30, 0);
    set_wb(1, 31, 0);
    set_wb(2, 0, 0);
    cyc();
    clear_wb();
    do_retire(3'b111, 0);
    #1;
    chk_state(29, 0, 0, 1);
    // asynchronous reset while a full retire group is presented
    set_wb(4, 1, 0);
    set_wb(5, 2, 0);
    set_wb(6, 3, 0);
    cyc();
    clear_wb();
    #1;
    chk("ret_valid_pre_reset", 64'(ret_valid), 64'(3'b111));
    ret_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ret_valid", 64'(ret_valid), 64'(0));
    chk("async_flush", 64'(flush), 64'(0));
    chk_state(0, 1, 0, 1);
    ret_ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    sb.delete();
    m_tail = 0;
    do_disp(3'b111, 1);
    #1;
    chk("count_post_reset", 64'(count), 64'(3));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
